// File: rtl/user_key_ctrl_pkg.sv
// Shared constants for the user key controller: register offsets and the
// bit position where release events start inside KEY_EVENT / IRQ_MASK.
package user_key_pkg;

  localparam logic [1:0] KEY_STATE_ADDR = 2'd0;
  localparam logic [1:0] KEY_EVENT_ADDR = 2'd1;
  localparam logic [1:0] IRQ_MASK_ADDR  = 2'd2;

  localparam int REL_BASE = 16;
  localparam int DATA_W   = 32;

  // Press field in [15:0], release field in [31:16].
  function automatic logic [DATA_W-1:0] pack_halves(input logic [15:0] lo,
                                                    input logic [15:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/user_key_ctrl_if.sv
// Word-addressed CPU bus into the key controller, plus its interrupt line.
interface user_key_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/user_key_ctrl_key_debounce.sv
// One key: two-flop synchroniser, stability counter, active-high debounced
// state, and single-cycle pulses on the cycle the state flips.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic i_key_n,
  output logic state,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_state;
  logic [CW-1:0] r_cnt;
  logic          w_samp, w_diff, w_flip;

  assign w_samp = ~r_sync2;
  assign w_diff = w_samp ^ r_state;
  // Flip on the edge the count would reach DEBOUNCE_CYCLES; it never wraps.
  assign w_flip = w_diff & (r_cnt == LAST);

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CW'(1);
      if (w_flip) r_state <= w_samp;
    end
  end

  assign state      = r_state;
  assign rise_pulse = w_flip &  w_samp;
  assign fall_pulse = w_flip & ~w_samp;

endmodule

// File: rtl/user_key_ctrl.sv
// Key peripheral: debounced state, sticky W1C press events and a maskable
// registered irq. Define USER_KEY_RELEASE_EVT_EN for release events in [KEYS+15:16].
module user_key_ctrl
  import user_key_pkg::*;
#(
  parameter int KEYS            = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk_in,
  input  logic            sys_rstn,
  input  logic [KEYS-1:0] user_key,
  user_key_ctrl_if.slave  bus
);

  logic [KEYS-1:0] w_state, w_rise, w_fall;
  logic [KEYS-1:0] r_evt_p, r_msk_p, w_evt_p_nxt, w_clr_p;
  logic            w_wr_evt, w_wr_msk, w_irq_src, r_irq;
  logic [15:0]     w_evt_hi, w_msk_hi;
  logic            w_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [KEYS-1:0] (
    .clk_in     (clk_in),
    .sys_rstn   (sys_rstn),
    .i_key_n    (user_key),
    .state      (w_state),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  assign w_wr_evt = bus.we && (bus.addr == KEY_EVENT_ADDR);
  assign w_wr_msk = bus.we && (bus.addr == IRQ_MASK_ADDR);

  // Set is OR-ed after the clear so a same-cycle press survives a W1C.
  assign w_clr_p     = w_wr_evt ? bus.wdata[KEYS-1:0] : '0;
  assign w_evt_p_nxt = w_rise | (r_evt_p & ~w_clr_p);

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_evt_p <= '0;
      r_msk_p <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_evt_p <= w_evt_p_nxt;
      if (w_wr_msk) r_msk_p <= bus.wdata[KEYS-1:0];
      r_irq <= w_irq_src;
    end
  end

`ifdef USER_KEY_RELEASE_EVT_EN
  logic [KEYS-1:0] r_evt_r, r_msk_r, w_evt_r_nxt, w_clr_r;

  assign w_clr_r     = w_wr_evt ? bus.wdata[REL_BASE +: KEYS] : '0;
  assign w_evt_r_nxt = w_fall | (r_evt_r & ~w_clr_r);

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_evt_r <= '0;
      r_msk_r <= '0;
    end else begin
      r_evt_r <= w_evt_r_nxt;
      if (w_wr_msk) r_msk_r <= bus.wdata[REL_BASE +: KEYS];
    end
  end

  assign w_irq_src = |(r_evt_p & r_msk_p) | |(r_evt_r & r_msk_r);
  assign w_evt_hi  = 16'(r_evt_r);
  assign w_msk_hi  = 16'(r_msk_r);
`else
  assign w_irq_src = |(r_evt_p & r_msk_p);
  assign w_evt_hi  = '0;
  assign w_msk_hi  = '0;
`endif

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      KEY_STATE_ADDR: bus.rdata = pack_halves(16'(w_state), 16'h0);
      KEY_EVENT_ADDR: bus.rdata = pack_halves(16'(r_evt_p), w_evt_hi);
      IRQ_MASK_ADDR:  bus.rdata = pack_halves(16'(r_msk_p), w_msk_hi);
      default:        bus.rdata = '0;
    endcase
  end

  assign bus.irq  = r_irq;
  assign w_unused = ^{bus.wdata, w_fall};

endmodule
